// File: rtl/rand_host_requester_pkg.sv
// Shared types for the TRNG host requester: request encoding, FSM states and size decode.
package rand_host_requester_pkg;

    // bit[2] selects RDRAND over RDSEED, [1:0] selects 16/32/64-bit result
    typedef struct packed {
        logic       rdrand;
        logic [1:0] size;
    } rand_req_t;

    localparam rand_req_t RDSEED_16 = '{rdrand: 1'b0, size: 2'd0};
    localparam rand_req_t RDSEED_32 = '{rdrand: 1'b0, size: 2'd1};
    localparam rand_req_t RDSEED_64 = '{rdrand: 1'b0, size: 2'd2};
    localparam rand_req_t RDRAND_16 = '{rdrand: 1'b1, size: 2'd0};
    localparam rand_req_t RDRAND_32 = '{rdrand: 1'b1, size: 2'd1};
    localparam rand_req_t RDRAND_64 = '{rdrand: 1'b1, size: 2'd2};

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RESP,
        DRAIN
    } host_req_state_t;

    // The reserved size code 3 falls back to a 16-bit request
    function automatic int unsigned req_bits(input rand_req_t t);
        case (t.size)
            2'd1:    return 32;
            2'd2:    return 64;
            default: return 16;
        endcase
    endfunction

endpackage

// File: rtl/rand_host_requester_if.sv
// Host command/response port plus the TRNG CPU pin bus, seen from the requester (master).
interface rand_host_requester_if #(
    parameter int OUTPUT_WIDTH = 16,
    parameter int RESULT_WIDTH = 64
);
    import rand_host_requester_pkg::*;

    logic                    cmd_valid;
    rand_req_t               cmd_type;
    logic                    cmd_ready;
    logic                    resp_valid;
    logic [RESULT_WIDTH-1:0] resp_data;
    logic                    resp_err;
    logic                    resp_ready;
    logic                    rand_req;
    rand_req_t               rand_req_type;
    logic [OUTPUT_WIDTH-1:0] rand_byte;
    logic                    rand_valid;
    logic                    slow_clk;

    modport master (
        input  cmd_valid, cmd_type, resp_ready, rand_byte, rand_valid, slow_clk,
        output cmd_ready, resp_valid, resp_data, resp_err, rand_req, rand_req_type
    );

    modport slave (
        output cmd_valid, cmd_type, resp_ready, rand_byte, rand_valid, slow_clk,
        input  cmd_ready, resp_valid, resp_data, resp_err, rand_req, rand_req_type
    );

endinterface

// File: rtl/rand_host_requester_pin_sync_edge.sv
// Two-flop synchronizer for an N-bit pin bus with rise/fall pulses derived from bit 0.
module pin_sync_edge #(
    parameter int N = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         rise,
    output logic         fall
);

    logic [N-1:0] sync_p0;
    logic [N-1:0] sync_p1;
    logic         edge_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            edge_p2 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
            edge_p2 <= sync_p1[0];
        end
    end

    assign q    = sync_p1;
    assign rise = sync_p1[0] & ~edge_p2;
    assign fall = ~sync_p1[0] & edge_p2;

endmodule

// File: rtl/rand_host_requester.sv
// Host-side TRNG requester: issues RDSEED/RDRAND on the pin bus, assembles the
// byte-sliced words into a 16/32/64-bit result and returns it over valid/ready.
module rand_host_requester
    import rand_host_requester_pkg::*;
#(
    parameter int OUTPUT_WIDTH    = 16,
    parameter int RESULT_WIDTH    = 64,
    parameter int TIMEOUT_PERIODS = 1023
) (
    input logic                   clk,
    input logic                   rst_n,
    rand_host_requester_if.master bus
);

    localparam int MAX_WORDS = RESULT_WIDTH / OUTPUT_WIDTH;
    localparam int CNT_W     = $clog2(MAX_WORDS) + 1;
    localparam int TMO_W     = $clog2(TIMEOUT_PERIODS + 1);
    localparam int SYNC_W    = OUTPUT_WIDTH + 2;

    function automatic logic [CNT_W-1:0] words_of(input rand_req_t t);
        return CNT_W'(req_bits(t) / OUTPUT_WIDTH);
    endfunction

    host_req_state_t         state;
    logic [CNT_W-1:0]        idx;
    logic [CNT_W-1:0]        words_q;
    logic [TMO_W-1:0]        tmo;
    logic [RESULT_WIDTH-1:0] shreg;
    logic [RESULT_WIDTH-1:0] merged;

    logic [SYNC_W-1:0]       pins_s;
    logic                    fall_p;
    logic                    slow_rise_unused;
    logic                    valid_s;
    logic [OUTPUT_WIDTH-1:0] byte_s;

    // slow_clk rides in bit 0 so its falling edge marks the middle of the data window
    pin_sync_edge #(.N(SYNC_W)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({bus.rand_byte, bus.rand_valid, bus.slow_clk}),
        .q    (pins_s),
        .rise (slow_rise_unused),
        .fall (fall_p)
    );

    assign valid_s = pins_s[1];
    assign byte_s  = pins_s[SYNC_W-1:2];

    always_comb begin
        merged = shreg;
        merged[idx * OUTPUT_WIDTH +: OUTPUT_WIDTH] = byte_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            idx               <= '0;
            words_q           <= '0;
            tmo               <= '0;
            bus.cmd_ready     <= 1'b1;
            bus.rand_req      <= 1'b0;
            bus.rand_req_type <= RDSEED_16;
            bus.resp_valid    <= 1'b0;
            bus.resp_data     <= '0;
            bus.resp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.cmd_ready     <= 1'b0;
                        bus.rand_req      <= 1'b1;
                        bus.rand_req_type <= bus.cmd_type;
                        words_q           <= words_of(bus.cmd_type);
                        idx               <= '0;
                        tmo               <= '0;
                        state             <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A valid word always beats the timeout, and restarts its window
                    if (fall_p && valid_s) begin
                        idx <= idx + CNT_W'(1);
                        tmo <= '0;
                        if (idx + CNT_W'(1) == words_q) begin
                            bus.rand_req   <= 1'b0;
                            bus.resp_valid <= 1'b1;
                            bus.resp_data  <= merged;
                            bus.resp_err   <= 1'b0;
                            state          <= RESP;
                        end
                    end else if (fall_p) begin
                        if (tmo == TMO_W'(TIMEOUT_PERIODS - 1)) begin
                            bus.rand_req   <= 1'b0;
                            bus.resp_valid <= 1'b1;
                            bus.resp_data  <= '0;
                            bus.resp_err   <= 1'b1;
                            state          <= RESP;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Wait until the TRNG has visibly closed the transfer
                    if (fall_p && !valid_s) begin
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.cmd_valid) begin
            shreg <= '0;
        end else if (state == COLLECT && fall_p && valid_s) begin
            shreg <= merged;
        end
    end

endmodule
